decode_pipe: RTL and testbench
==============================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: operand and immediate width.
REQ-002 SHALL have parameter DECODE_NUM, default 4: instruction slots per bundle.
REQ-003 SHALL have parameter BUF_DEPTH, default 2: output buffer entries; legal values are 2..4.
REQ-004 SHALL have port clk, input, 1: the single clock; all state on the rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset; asynchronous, active-low.
REQ-006 SHALL have port flush, input, 1: discard all buffered bundles.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1): input handshake.
REQ-008 SHALL have port instr, input, DECODE_NUM x 32: raw instructions.
REQ-009 SHALL have port in_mask, input, DECODE_NUM: per-slot valid bit.
REQ-010 SHALL have ports out_valid (output, 1), out_ready (input, 1): output handshake.
REQ-011 SHALL have port out_mask, output, DECODE_NUM: per-slot valid bit of the head bundle.
REQ-012 SHALL have output ports opcode[7], func3[3], func7[1], rs1[5], rs2[5], rd[5], imme[DATA_WIDTH], each DECODE_NUM-wide arrays.
REQ-013 SHALL have output ports prs1_v, prs2_v, prd_v, illegal, each DECODE_NUM bits.

Function
REQ-014 SHALL decode each slot combinationally at the input: field extraction, type classification (R/I/U/J/B/S), and immediate sign-extension to DATA_WIDTH.
- Definitions: R = R_type, Rw_type; I = jalr, load, I_type, Iw_type; U = lui, auipc; J = jal; B = B_type; S = store.
REQ-015 SHALL set prs1_v = R|I|S|B, prs2_v = R|S|B and prd_v = R|I|U|J per slot, evaluated for that slot only (no vector OR-reduction).
REQ-016 SHALL store decoded bundles in a BUF_DEPTH-entry FIFO, so input-to-output latency is exactly 1 cycle when the FIFO is empty.
REQ-017 SHALL drive in_ready = (count < BUF_DEPTH) from registered state only, with no combinational path from out_ready.
REQ-018 SHALL push a bundle when in_valid & in_ready, and pop when out_valid & out_ready.
REQ-019 SHALL drive out_valid = (count != 0) and present the head entry on all output fields.
- A simultaneous push and pop leaves count unchanged.
- Full: no push.
- Empty: no pop.
- Read and write pointers wrap modulo BUF_DEPTH.
REQ-020 SHALL force opcode, fields, imme, prs*/prd_v and illegal to zero for slots with in_mask=0.
REQ-021 SHALL, on flush, zero count and both pointers in the next cycle.
- Flush dominates a same-cycle push.
- A same-cycle pop is also discarded.
REQ-022 SHALL hold all outputs stable while out_valid & !out_ready.

Reset
REQ-023 SHALL, when rst_n=0, asynchronously clear count, pointers, out_valid and out_mask to 0 and drive all decoded outputs to 0.
- Reset mid-transfer drops all buffered bundles.
- in_ready becomes 1 in the first cycle after release.

Configuration
REQ-024 SHALL use the macro DECODE_ILLEGAL_CHK_EN.
- Defined: illegal[i]=1 for a valid slot whose opcode matches no known type, and prs1_v, prs2_v, prd_v and imme are 0 for that slot.
- Undefined: illegal is tied to 0, and unknown opcodes decode with all valid flags 0.

Structure
REQ-025 SHALL place the opcode constants (R_type, Rw_type, I_type, Iw_type, load, store, B_type, jal, jalr, lui, auipc) and the instruction-type enum in the shared package decode_pkg.
REQ-026 SHALL instantiate one combinational sub-module decode_slot per slot; the FIFO stays inline in decode_pipe.

Verification
REQ-027 SHALL cover addi 0xFFF10093 in slot 0, mask 0001 -> next cycle: opcode 0x13, rd=1, rs1=2, imme=0xFFFFFFFFFFFFFFFF, prs1_v=1, prs2_v=0, prd_v=1, out_mask=0001.
REQ-028 SHALL cover sw 0x00512423 and lui 0x800001B7 in one bundle:
- sw: imme=8, prs2_v=1, prd_v=0.
- lui: imme=0xFFFFFFFF80000000, prs1_v=0, prd_v=1.
REQ-029 SHALL cover backpressure with out_ready=0 and 3 bundles offered on consecutive cycles (BUF_DEPTH=2):
- in_ready=0 after the 2nd bundle; the 3rd is held.
- After out_ready=1, the bundles emerge in order A, B, C with no loss.
REQ-030 SHALL cover flush asserted with count=1 and in_valid=1 in the same cycle -> next cycle: out_valid=0, in_ready=1, and the offered bundle is dropped.
REQ-031 SHALL cover instr 0x0000007F with mask 0001:
- Macro defined: illegal=0001 and all valid flags 0.
- Macro undefined: illegal=0.
REQ-032 SHALL cover rst_n pulled low while count=2 -> outputs are 0 immediately; after release, out_valid=0 and in_ready=1.

Source files
------------

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared opcode constants, instruction-type enum and decoded-slot struct
package decode_pkg;

  localparam logic [6:0] R_type  = 7'b0110011;
  localparam logic [6:0] Rw_type = 7'b0111011;
  localparam logic [6:0] I_type  = 7'b0010011;
  localparam logic [6:0] Iw_type = 7'b0011011;
  localparam logic [6:0] load    = 7'b0000011;
  localparam logic [6:0] store   = 7'b0100011;
  localparam logic [6:0] B_type  = 7'b1100011;
  localparam logic [6:0] jal     = 7'b1101111;
  localparam logic [6:0] jalr    = 7'b1100111;
  localparam logic [6:0] lui     = 7'b0110111;
  localparam logic [6:0] auipc   = 7'b0010111;

  typedef enum logic [2:0] {T_NONE, T_R, T_I, T_U, T_J, T_B, T_S} inst_type_e;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       func7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       prs1_v;
    logic       prs2_v;
    logic       prd_v;
    logic       illegal;
  } slot_dec_t;

  function automatic inst_type_e classify(input logic [6:0] op);
    case (op)
      R_type, Rw_type:              return T_R;
      jalr, load, I_type, Iw_type:  return T_I;
      lui, auipc:                   return T_U;
      jal:                          return T_J;
      B_type:                       return T_B;
      store:                        return T_S;
      default:                      return T_NONE;
    endcase
  endfunction

endpackage

// File: rtl/decode_slot.sv
// rtl/decode_slot.sv - combinational decode of one instruction slot
// Unknown-opcode flagging is enabled by DECODE_ILLEGAL_CHK_EN.
module decode_slot
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [31:0]           instr,
  input  logic                  valid,
  output slot_dec_t             dec,
  output logic [DATA_WIDTH-1:0] imme
);

  inst_type_e  typ;
  logic        is_r, is_i, is_u, is_j, is_b, is_s;
  logic [31:0] imm32;

  always_comb begin
    typ  = classify(instr[6:0]);
    is_r = (typ == T_R);
    is_i = (typ == T_I);
    is_u = (typ == T_U);
    is_j = (typ == T_J);
    is_b = (typ == T_B);
    is_s = (typ == T_S);

    case (typ)
      T_I:     imm32 = {{20{instr[31]}}, instr[31:20]};
      T_S:     imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      T_B:     imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      T_U:     imm32 = {instr[31:12], 12'b0};
      T_J:     imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase

    // Masked-off slots present all-zero so downstream never sees stale fields.
    dec  = '0;
    imme = '0;
    if (valid) begin
      dec.opcode = instr[6:0];
      dec.func3  = instr[14:12];
      dec.func7  = instr[30];
      dec.rs1    = instr[19:15];
      dec.rs2    = instr[24:20];
      dec.rd     = instr[11:7];
      dec.prs1_v = is_r | is_i | is_s | is_b;
      dec.prs2_v = is_r | is_s | is_b;
      dec.prd_v  = is_r | is_i | is_u | is_j;
`ifdef DECODE_ILLEGAL_CHK_EN
      dec.illegal = (typ == T_NONE);
`endif
      imme = DATA_WIDTH'($signed(imm32));
    end
  end

endmodule

// File: rtl/decode_pipe.sv
// rtl/decode_pipe.sv - bundle decoder: per-slot decode feeding a BUF_DEPTH-entry output FIFO
// Optional illegal-opcode detection under DECODE_ILLEGAL_CHK_EN.
module decode_pipe
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DECODE_NUM = 4,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  flush,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [DECODE_NUM-1:0][31:0]           instr,
  input  logic [DECODE_NUM-1:0]                 in_mask,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DECODE_NUM-1:0]                 out_mask,
  output logic [DECODE_NUM-1:0][6:0]            opcode,
  output logic [DECODE_NUM-1:0][2:0]            func3,
  output logic [DECODE_NUM-1:0]                 func7,
  output logic [DECODE_NUM-1:0][4:0]            rs1,
  output logic [DECODE_NUM-1:0][4:0]            rs2,
  output logic [DECODE_NUM-1:0][4:0]            rd,
  output logic [DECODE_NUM-1:0][DATA_WIDTH-1:0] imme,
  output logic [DECODE_NUM-1:0]                 prs1_v,
  output logic [DECODE_NUM-1:0]                 prs2_v,
  output logic [DECODE_NUM-1:0]                 prd_v,
  output logic [DECODE_NUM-1:0]                 illegal
);

  localparam int PW = (BUF_DEPTH > 2) ? 2 : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);

  slot_dec_t [DECODE_NUM-1:0]                 in_dec;
  logic      [DECODE_NUM-1:0][DATA_WIDTH-1:0] in_imme;

  for (genvar g = 0; g < DECODE_NUM; g++) begin : g_slot
    decode_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
      .instr (instr[g]),
      .valid (in_mask[g]),
      .dec   (in_dec[g]),
      .imme  (in_imme[g])
    );
  end

  slot_dec_t [DECODE_NUM-1:0]                 buf_dec  [BUF_DEPTH];
  logic      [DECODE_NUM-1:0][DATA_WIDTH-1:0] buf_imme [BUF_DEPTH];
  logic      [DECODE_NUM-1:0]                 buf_mask [BUF_DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;
  slot_dec_t     hd;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (count < CW'(BUF_DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Payload storage needs no reset: it is only visible while count is nonzero.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_dec[wr_ptr]  <= in_dec;
      buf_imme[wr_ptr] <= in_imme;
      buf_mask[wr_ptr] <= in_mask;
    end
  end

  always_comb begin
    hd       = '0;
    out_mask = out_valid ? buf_mask[rd_ptr] : '0;
    for (int k = 0; k < DECODE_NUM; k++) begin
      hd         = out_valid ? buf_dec[rd_ptr][k] : '0;
      opcode[k]  = hd.opcode;
      func3[k]   = hd.func3;
      func7[k]   = hd.func7;
      rs1[k]     = hd.rs1;
      rs2[k]     = hd.rs2;
      rd[k]      = hd.rd;
      prs1_v[k]  = hd.prs1_v;
      prs2_v[k]  = hd.prs2_v;
      prd_v[k]   = hd.prd_v;
      illegal[k] = hd.illegal;
      imme[k]    = out_valid ? buf_imme[rd_ptr][k] : '0;
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
// tb/tb_decode_pipe.sv - directed scoreboard bench for decode_pipe (honours DECODE_ILLEGAL_CHK_EN)
module tb_decode_pipe;

  typedef struct packed {
    logic [3:0]        mask;
    logic [3:0][6:0]   opc;
    logic [3:0][2:0]   f3;
    logic [3:0][4:0]   rs1;
    logic [3:0][4:0]   rs2;
    logic [3:0][4:0]   rd;
    logic [3:0][63:0]  imm;
    logic [3:0]        p1;
    logic [3:0]        p2;
    logic [3:0]        pd;
    logic [3:0]        ill;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0][31:0] instr = '0;
  logic [3:0]       in_mask = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [3:0]       out_mask;
  logic [3:0][6:0]  opcode;
  logic [3:0][2:0]  func3;
  logic [3:0]       func7;
  logic [3:0][4:0]  rs1, rs2, rd;
  logic [3:0][63:0] imme;
  logic [3:0]       prs1_v, prs2_v, prd_v, illegal;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  exp_t e;

  decode_pipe #(.DATA_WIDTH(64), .DECODE_NUM(4), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask),
    .opcode(opcode), .func3(func3), .func7(func7), .rs1(rs1), .rs2(rs2), .rd(rd),
    .imme(imme), .prs1_v(prs1_v), .prs2_v(prs2_v), .prd_v(prd_v), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] s1, input logic [4:0] d);
    return {imm, s1, 3'b000, d, 7'h13};
  endfunction

  function automatic logic [31:0] enc_add(input logic [4:0] s2, input logic [4:0] s1, input logic [4:0] d);
    return {7'b0, s2, s1, 3'b000, d, 7'h33};
  endfunction

  task automatic check_head(input string tag);
    exp_t x;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=unexpected_bundle expected=none", tag);
      return;
    end
    x = sb.pop_front();
    chk({tag, "_mask"}, out_mask, x.mask);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_s%0d_opcode", tag, k), opcode[k], x.opc[k]);
      chk($sformatf("%s_s%0d_func3", tag, k), func3[k], x.f3[k]);
      chk($sformatf("%s_s%0d_rs1", tag, k), rs1[k], x.rs1[k]);
      chk($sformatf("%s_s%0d_rs2", tag, k), rs2[k], x.rs2[k]);
      chk($sformatf("%s_s%0d_rd", tag, k), rd[k], x.rd[k]);
      chk($sformatf("%s_s%0d_imme", tag, k), imme[k], x.imm[k]);
      chk($sformatf("%s_s%0d_flags", tag, k), {prs1_v[k], prs2_v[k], prd_v[k], illegal[k]},
          {x.p1[k], x.p2[k], x.pd[k], x.ill[k]});
    end
  endtask

  task automatic drain_one(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    if (!out_valid) chk({tag, "_timeout"}, out_valid, 1'b1);
    else begin
      check_head(tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_mask", out_mask, 4'b0);
    #10 rst_n = 1'b1;
    tick();
    chk("post_rst_out_valid", out_valid, 1'b0);
    chk("post_rst_in_ready", in_ready, 1'b1);

    // addi x1, x2, -1 in slot 0
    instr = '0; instr[0] = 32'hFFF10093; in_mask = 4'b0001; in_valid = 1'b1;
    e = '0; e.mask = 4'b0001; e.opc[0] = 7'h13; e.rd[0] = 5'd1; e.rs1[0] = 5'd2; e.rs2[0] = 5'd31;
    e.imm[0] = 64'hFFFF_FFFF_FFFF_FFFF; e.p1[0] = 1'b1; e.pd[0] = 1'b1;
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
    chk("addi_latency", out_valid, 1'b1);
    drain_one("addi");

    // sw + lui in one bundle; masked slots carry junk that must not leak
    instr[0] = 32'h00512423; instr[1] = 32'h800001B7; instr[2] = 32'hFFFFFFFF; instr[3] = 32'h00000013;
    in_mask = 4'b0011; in_valid = 1'b1;
    e = '0; e.mask = 4'b0011;
    e.opc[0] = 7'h23; e.f3[0] = 3'd2; e.rs1[0] = 5'd2; e.rs2[0] = 5'd5; e.rd[0] = 5'd8;
    e.imm[0] = 64'd8; e.p1[0] = 1'b1; e.p2[0] = 1'b1;
    e.opc[1] = 7'h37; e.rd[1] = 5'd3; e.imm[1] = 64'hFFFF_FFFF_8000_0000; e.pd[1] = 1'b1;
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
    drain_one("sw_lui");

    // backpressure: A, B fill the buffer, C must wait
    out_ready = 1'b0;
    instr = '0; instr[0] = enc_i(12'd5, 5'd1, 5'd5); in_mask = 4'b0001; in_valid = 1'b1;
    e = '0; e.mask = 4'b0001; e.opc[0] = 7'h13; e.rs1[0] = 5'd1; e.rs2[0] = 5'd5; e.rd[0] = 5'd5;
    e.imm[0] = 64'd5; e.p1[0] = 1'b1; e.pd[0] = 1'b1;
    sb.push_back(e);
    tick();
    chk("bp_ready_after_a", in_ready, 1'b1);
    instr = '0; instr[1] = enc_i(12'hFFE, 5'd2, 5'd6); in_mask = 4'b0010;
    e = '0; e.mask = 4'b0010; e.opc[1] = 7'h13; e.rs1[1] = 5'd2; e.rs2[1] = 5'd30; e.rd[1] = 5'd6;
    e.imm[1] = 64'hFFFF_FFFF_FFFF_FFFE; e.p1[1] = 1'b1; e.pd[1] = 1'b1;
    sb.push_back(e);
    tick();
    chk("bp_full_after_b", in_ready, 1'b0);
    instr = '0; instr[2] = enc_add(5'd4, 5'd3, 5'd7); in_mask = 4'b0100;
    e = '0; e.mask = 4'b0100; e.opc[2] = 7'h33; e.rs1[2] = 5'd3; e.rs2[2] = 5'd4; e.rd[2] = 5'd7;
    e.p1[2] = 1'b1; e.p2[2] = 1'b1; e.pd[2] = 1'b1;
    sb.push_back(e);
    tick();
    tick();
    chk("bp_c_held", in_ready, 1'b0);
    chk("bp_hold_valid", out_valid, 1'b1);
    chk("bp_hold_mask", out_mask, 4'b0001);
    chk("bp_hold_imme", imme[0], 64'd5);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (sb.size() > 0 || in_valid); c++) begin
      logic fin;
      fin = in_valid & in_ready;
      if (out_valid) check_head("bp");
      tick();
      if (fin) in_valid = 1'b0;
    end
    chk("bp_all_out", 64'(sb.size()), 64'd0);
    chk("bp_empty_after", out_valid, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b0;

    // flush with one buffered bundle and a simultaneous offer
    instr = '0; instr[0] = enc_i(12'd1, 5'd1, 5'd1); in_mask = 4'b0001; in_valid = 1'b1;
    tick();
    chk("fl_count1", out_valid, 1'b1);
    flush = 1'b1; instr[0] = enc_i(12'd2, 5'd2, 5'd2);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", out_valid, 1'b0);
    chk("fl_in_ready", in_ready, 1'b1);
    tick();
    tick();
    chk("fl_offer_dropped", out_valid, 1'b0);

    // unknown opcode
    instr = '0; instr[0] = 32'h0000007F; in_mask = 4'b0001; in_valid = 1'b1;
    e = '0; e.mask = 4'b0001; e.opc[0] = 7'h7F;
`ifdef DECODE_ILLEGAL_CHK_EN
    e.ill[0] = 1'b1;
`endif
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
    drain_one("illegal");

    // reset with two buffered bundles
    instr = '0; instr[0] = enc_i(12'd9, 5'd3, 5'd4); in_mask = 4'b0001; in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    chk("mr_full", in_ready, 1'b0);
    chk("mr_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mr_out_valid", out_valid, 1'b0);
    chk("mr_out_mask", out_mask, 4'b0);
    chk("mr_opcode", opcode[0], 7'h0);
    chk("mr_imme", imme[0], 64'h0);
    chk("mr_prd_v", prd_v, 4'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mr_rel_out_valid", out_valid, 1'b0);
    chk("mr_rel_in_ready", in_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
